cpu_screen_mirror: RTL and testbench
====================================

Name: cpu_screen_mirror

Overview:
- Consumer end of the CPU data-memory mirror write stream (write_m / data_addr / out_m).
- Snoops every CPU store, keeps a private shadow copy of the Hack screen window, and serves pixel lookups to the VGA pixel pipeline at a fixed latency.
- Tracks per-frame dirtiness and a store counter for the VGA/debug logic.
- Sits beside the cpu, in the same clock domain.

Parameters:
- SCREEN_BASE, 16384, first data address of the screen window.
- ROW_WORDS, 32, 16-bit words per screen row (512 pixels).
- ROWS, 256, screen rows; window size is ROW_WORDS*ROWS words.
- CNT_W, 16, width of the store counter.

Ports:
- clk  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- write_m  in  1  CPU store strobe; one store per cycle when high.
- data_addr  in  15  CPU store address.
- out_m  in  16  CPU store data.
- pix_req  in  1  pixel lookup request, may be high every cycle.
- pix_x  in  10  pixel column.
- pix_y  in  9  pixel row.
- vsync_clr  in  1  frame boundary pulse; clears frame_dirty.
- pix_valid  out  1  response strobe.
- pix_on  out  1  pixel value.
- frame_dirty  out  1  sticky flag: a screen store occurred since the last vsync_clr.
- store_cnt  out  CNT_W  number of accepted screen stores.

Behaviour:
- Reset (resetN low, asynchronous): pix_valid=0, pix_on=0, frame_dirty=0, store_cnt=0, pipeline valids=0. Shadow RAM content is not reset; it reads 0 in simulation only if initialised.
- Store accept: in_win = write_m && data_addr >= SCREEN_BASE && data_addr < SCREEN_BASE+ROW_WORDS*ROWS.
  - When in_win is high, the shadow word at offset (data_addr-SCREEN_BASE) is written on that clock edge.
  - Stores outside the window are ignored entirely: no RAM write, no flag, no count.
- store_cnt increments by 1 per accepted store and wraps from 2^CNT_W-1 to 0.
- frame_dirty:
  - Set on an accepted store.
  - Cleared by vsync_clr.
  - If both happen in the same cycle, the set wins and frame_dirty=1.
- Pixel lookup pipeline, fixed 2-cycle latency:
  - Request sampled at edge N; pix_valid=1 and pix_on are registered outputs valid after edge N+2.
  - Requests are never dropped or stalled.
- Address math, stage 1:
  - word_off = pix_y*ROW_WORDS + pix_x[9:4].
  - bit = pix_x[3:0]; bit 0 of a word is the leftmost pixel.
  - out_of_range = (pix_y >= ROWS) || (pix_x >= ROW_WORDS*16).
- Stage 2: synchronous RAM read of word_off. Stage 3: bit select, registered.
- Out-of-range request: pix_valid=1, pix_on=0, and no RAM read is used.
- Read-after-write forwarding:
  - An accepted store to the same word_off in the request cycle N or cycle N+1 must be visible in the response.
  - The youngest store wins; the response always reflects every store accepted up to and including cycle N+1.
  - Stores from cycle N+2 onward do not affect that response.
- pix_valid tracks pix_req delayed by 2 cycles exactly, with no bubbles.
- Reset mid-operation: in-flight requests are discarded; no pix_valid appears after reset release until a new request has completed its 2 cycles.
- The block never drives anything back to the cpu.

Test Plan:
- Reset: hold resetN=0, then release → pix_valid=0, frame_dirty=0, store_cnt=0. Issue a request with no stores → pix_valid after 2 cycles.
- Store filter: store 0x0001 @16384, store 0xFFFF @100, store 0x8000 @24575 → store_cnt=2, frame_dirty=1. Request (0,0) → pix_on=1. Request (511,255) → pix_on=1.
- Bit mapping: store 0x0004 @16384+33. Request x=18, y=1 → pix_on=1. Request x=17, y=1 → pix_on=0.
- Forwarding: in cycle N, store 0x0001 @16384 and request (0,0) → response at N+2 shows pix_on=1. Then store 0x0000 at N+1 on a second request issued at N → pix_on=0.
- Boundaries:
  - Request x=600 or y=300 → pix_valid=1, pix_on=0.
  - Store at 16384+8192 → ignored, store_cnt unchanged.
  - With store_cnt=0xFFFF, one more store → 0x0000.
- Flag race and mid-op reset:
  - vsync_clr and an accepted store in the same cycle → frame_dirty=1.
  - vsync_clr alone → 0.
  - Assert resetN=0 with 2 requests in flight → no pix_valid after release.

Source files
------------

// File: rtl/cpu_screen_mirror_if.sv
// CPU store snoop and pixel lookup signals for the screen mirror; master drives stores and lookups.
// Responses come back 2 cycles after a request and cannot be backpressured.
interface cpu_screen_mirror_if #(
    parameter int CNT_W = 16
);
    logic             write_m;
    logic [14:0]      data_addr;
    logic [15:0]      out_m;
    logic             pix_req;
    logic [9:0]       pix_x;
    logic [8:0]       pix_y;
    logic             vsync_clr;
    logic             pix_valid;
    logic             pix_on;
    logic             frame_dirty;
    logic [CNT_W-1:0] store_cnt;

    modport master (
        output write_m, data_addr, out_m, pix_req, pix_x, pix_y, vsync_clr,
        input  pix_valid, pix_on, frame_dirty, store_cnt
    );

    modport slave (
        input  write_m, data_addr, out_m, pix_req, pix_x, pix_y, vsync_clr,
        output pix_valid, pix_on, frame_dirty, store_cnt
    );
endinterface

// File: rtl/cpu_screen_mirror.sv
// Shadow copy of the Hack screen fed by CPU stores; pixel lookups return after a fixed 2 cycles.
// No backpressure: a lookup may be issued every cycle and is never dropped or stalled.
module cpu_screen_mirror #(
    parameter int SCREEN_BASE = 16384,
    parameter int ROW_WORDS   = 32,
    parameter int ROWS        = 256,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               resetN,
    cpu_screen_mirror_if.slave bus
);
    localparam int              WORDS  = ROW_WORDS * ROWS;
    localparam int              AW     = $clog2(WORDS);
    localparam logic [14:0]     BASE_A = 15'(SCREEN_BASE);
    localparam logic [15:0]     END_A  = 16'(SCREEN_BASE + WORDS);
    localparam logic [AW-1:0]   RW_A   = AW'(ROW_WORDS);
    localparam logic [9:0]      XMAX   = 10'(ROW_WORDS * 16);
    localparam logic [8:0]      YMAX   = 9'(ROWS);

    logic [15:0]      mem [WORDS];

    logic             in_win;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    word_off_d;
    logic             oor_d;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             dirty_d, dirty_q;

    logic             v1_q, oor1_q;
    logic [AW-1:0]    off1_q;
    logic [3:0]       bit1_q;
    logic             v2_q, oor2_q;
    logic [3:0]       bit2_q;
    logic [15:0]      word2_q;
    logic             valid_q, on_q;

    always_comb begin
        in_win     = bus.write_m && (bus.data_addr >= BASE_A) && ({1'b0, bus.data_addr} < END_A);
        waddr      = AW'(bus.data_addr - BASE_A);
        word_off_d = AW'(bus.pix_y) * RW_A + AW'(bus.pix_x[9:4]);
        oor_d      = (bus.pix_y >= YMAX) || (bus.pix_x >= XMAX);
        cnt_d      = in_win ? cnt_q + 1'b1 : cnt_q;
        // A store in the same cycle as a frame clear keeps the flag set
        dirty_d    = in_win || (dirty_q && !bus.vsync_clr);
    end

    // A store landing on the word being read this edge is forwarded over the stale RAM data
    always_ff @(posedge clk) begin
        if (in_win) begin
            mem[waddr] <= bus.out_m;
        end
        if (v1_q && !oor1_q) begin
            word2_q <= (in_win && (waddr == off1_q)) ? bus.out_m : mem[off1_q];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            v1_q    <= 1'b0;
            oor1_q  <= 1'b0;
            off1_q  <= '0;
            bit1_q  <= '0;
            v2_q    <= 1'b0;
            oor2_q  <= 1'b0;
            bit2_q  <= '0;
            valid_q <= 1'b0;
            on_q    <= 1'b0;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            v1_q    <= bus.pix_req;
            oor1_q  <= oor_d;
            off1_q  <= word_off_d;
            bit1_q  <= bus.pix_x[3:0];
            v2_q    <= v1_q;
            oor2_q  <= oor1_q;
            bit2_q  <= bit1_q;
            valid_q <= v2_q;
            on_q    <= v2_q && !oor2_q && word2_q[bit2_q];
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
        end
    end

    assign bus.pix_valid   = valid_q;
    assign bus.pix_on      = on_q;
    assign bus.frame_dirty = dirty_q;
    assign bus.store_cnt   = cnt_q;
endmodule

// File: tb/tb_cpu_screen_mirror.sv
// Bench for cpu_screen_mirror: directed cases with literal expectations plus randomized traffic
// compared every cycle against a word-array model of the screen.
module tb_cpu_screen_mirror;
    localparam int BASE  = 16384;
    localparam int RW    = 32;
    localparam int ROWS  = 256;
    localparam int WORDS = RW * ROWS;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    cpu_screen_mirror_if #(.CNT_W(16)) bus();

    cpu_screen_mirror #(
        .SCREEN_BASE(BASE), .ROW_WORDS(RW), .ROWS(ROWS), .CNT_W(16)
    ) dut (
        .clk(clk), .resetN(resetN), .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_window(int a);
        return (a >= BASE) && (a < BASE + WORDS);
    endfunction

    // Model: screen as a plain word array; a response reflects every store up to one
    // cycle after its request and is presented one cycle after that.
    logic [15:0] m_mem [WORDS];
    bit          m_known [WORDS];
    logic [15:0] m_cnt = '0;
    bit          m_dirty = 0;
    bit          q_vld = 0, res_vld = 0, res_on = 0, res_known = 0;
    bit          exp_vld = 0, exp_on = 0, exp_known = 0;
    int          q_x = 0, q_y = 0;

    always @(posedge clk or negedge resetN) begin : model
        int a, off, bt;
        bit acc;
        if (!resetN) begin
            m_cnt = '0; m_dirty = 0;
            q_vld = 0; res_vld = 0; res_on = 0; res_known = 0;
            exp_vld = 0; exp_on = 0; exp_known = 0;
        end else begin
            exp_vld = res_vld; exp_on = res_on; exp_known = res_known;
            a   = int'(bus.data_addr);
            acc = bus.write_m && in_window(a);
            if (acc) begin
                m_mem[a - BASE]   = bus.out_m;
                m_known[a - BASE] = 1;
                m_cnt++;
            end
            if (acc) m_dirty = 1;
            else if (bus.vsync_clr) m_dirty = 0;
            res_vld = q_vld; res_on = 0; res_known = 1;
            if (q_vld && q_y < ROWS && q_x < RW * 16) begin
                off       = q_y * RW + q_x / 16;
                bt        = q_x % 16;
                res_on    = m_mem[off][bt];
                res_known = m_known[off];
            end
            q_vld = bus.pix_req;
            q_x   = int'(bus.pix_x);
            q_y   = int'(bus.pix_y);
        end
    end

    always @(negedge clk) begin
        check("pix_valid", int'(bus.pix_valid), int'(exp_vld));
        if (exp_vld && exp_known) check("pix_on", int'(bus.pix_on), int'(exp_on));
        check("frame_dirty", int'(bus.frame_dirty), int'(m_dirty));
        check("store_cnt", int'(bus.store_cnt), int'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_m = 0; bus.data_addr = '0; bus.out_m = '0;
        bus.pix_req = 0; bus.pix_x = '0; bus.pix_y = '0; bus.vsync_clr = 0;
    endtask

    task automatic st(int a, int d);
        bus.write_m = 1; bus.data_addr = 15'(a); bus.out_m = 16'(d);
    endtask

    task automatic rq(int x, int y);
        bus.pix_req = 1; bus.pix_x = 10'(x); bus.pix_y = 9'(y);
    endtask

    task automatic one_req(string nm, int x, int y, int exp);
        idle(); rq(x, y); tick();
        idle(); tick(); tick();
        check({nm, "_vld"}, int'(bus.pix_valid), 1);
        check(nm, int'(bus.pix_on), exp);
    endtask

    int a, off, x, y, cnt_before;
    int bnd [4] = '{BASE - 1, BASE, BASE + WORDS - 1, BASE + WORDS};

    initial begin : stim
        int last_off;
        last_off = 0;
        idle();
        resetN = 0;
        repeat (3) tick();
        resetN = 1;
        check("rst_vld", int'(bus.pix_valid), 0);
        check("rst_on", int'(bus.pix_on), 0);
        check("rst_dirty", int'(bus.frame_dirty), 0);
        check("rst_cnt", int'(bus.store_cnt), 0);
        rq(5, 5); tick();
        idle(); tick();
        check("lat_early", int'(bus.pix_valid), 0);
        tick();
        check("lat_vld", int'(bus.pix_valid), 1);

        // store filter
        st(BASE, 'h0001); tick();
        st(100, 'hFFFF); tick();
        st(BASE + WORDS - 1, 'h8000); tick();
        idle(); tick();
        check("filt_cnt", int'(bus.store_cnt), 2);
        check("filt_dirty", int'(bus.frame_dirty), 1);
        one_req("px_0_0", 0, 0, 1);
        one_req("px_511_255", 511, 255, 1);

        // bit mapping
        st(BASE + 33, 'h0004); tick(); idle();
        one_req("px_18_1", 18, 1, 1);
        one_req("px_17_1", 17, 1, 0);

        // forwarding
        st(BASE, 'h0000); tick(); idle(); tick();
        st(BASE, 'h0001); rq(0, 0); tick();
        idle(); tick(); tick();
        check("fw_same", int'(bus.pix_on), 1);
        idle(); rq(0, 0); tick();
        idle(); st(BASE, 'h0000); tick();
        idle(); tick();
        check("fw_next", int'(bus.pix_on), 0);
        idle(); rq(0, 0); tick();
        idle(); tick();
        st(BASE, 'h0001); tick();
        check("fw_late", int'(bus.pix_on), 0);
        idle(); rq(0, 0); st(BASE, 'h0000); tick();
        idle(); st(BASE, 'h0001); tick();
        idle(); tick();
        check("fw_young", int'(bus.pix_on), 1);

        // out-of-range lookups, with the aliased words set so a leak would show
        st(BASE + 37, 'hFFFF); tick();
        st(BASE + 1408, 'hFFFF); tick();
        st(BASE + 32, 'hFFFF); tick();
        idle();
        one_req("oor_x600", 600, 0, 0);
        one_req("oor_y300", 0, 300, 0);
        one_req("oor_x512", 512, 0, 0);

        // stores outside the window
        bus.vsync_clr = 1; tick(); idle();
        cnt_before = int'(m_cnt);
        st(BASE + WORDS, 'h1234); tick();
        st(BASE - 1, 'h1234); tick();
        idle(); tick();
        check("oow_cnt", int'(bus.store_cnt), cnt_before);
        check("oow_dirty", int'(bus.frame_dirty), 0);

        // randomized mixed traffic
        for (int i = 0; i < 3000; i++) begin
            idle();
            if ($urandom % 2 == 0) begin
                case ($urandom % 8)
                    0: a = int'($urandom % BASE);
                    1: a = BASE + WORDS + int'($urandom % (32768 - BASE - WORDS));
                    2: a = bnd[$urandom % 4];
                    3: a = BASE + last_off;
                    default: a = BASE + int'($urandom % WORDS);
                endcase
                st(a, int'($urandom));
            end
            if ($urandom % 4 != 0) begin
                case ($urandom % 4)
                    0: off = -1;
                    1: off = last_off;
                    2: off = (bus.write_m && in_window(int'(bus.data_addr)))
                             ? int'(bus.data_addr) - BASE : int'($urandom % WORDS);
                    default: off = int'($urandom % WORDS);
                endcase
                if (off < 0) begin
                    x = int'($urandom % 1024); y = int'($urandom % 512);
                end else begin
                    x = (off % RW) * 16 + int'($urandom % 16); y = off / RW;
                    last_off = off;
                end
                rq(x, y);
            end
            bus.vsync_clr = ($urandom % 8 == 0);
            tick();
        end

        // flag race
        idle(); st(BASE + 5, 'h00F0); bus.vsync_clr = 1; tick();
        check("race_dirty", int'(bus.frame_dirty), 1);
        idle(); bus.vsync_clr = 1; tick();
        check("clr_dirty", int'(bus.frame_dirty), 0);

        // drive the counter to its top value and across the wrap
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) begin
            idle();
            st(BASE + int'($urandom % WORDS), int'($urandom));
            if ($urandom % 2 == 0) rq(int'($urandom % 1024), int'($urandom % 512));
            tick();
        end
        idle(); tick();
        check("cnt_max", int'(bus.store_cnt), 'hFFFF);
        st(BASE + 7, 'h0003); tick();
        idle(); tick();
        check("cnt_wrap", int'(bus.store_cnt), 0);

        // reset with two lookups in flight
        rq(1, 1); tick();
        rq(2, 1); tick();
        resetN = 0; idle();
        tick(); tick();
        resetN = 1;
        check("mid_rst_cnt", int'(bus.store_cnt), 0);
        check("mid_rst_dirty", int'(bus.frame_dirty), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_vld", int'(bus.pix_valid), 0);
        end
        st(BASE, 'h0001); tick(); idle();
        one_req("post_rst", 0, 0, 1);

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        n_errors++;
        $display("FAIL watchdog: got timeout want finished run");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
